// File: rtl/vehicle_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : vehicle_sensor_conditioner
// Purpose  : Conditions raw CPU temperature and fuel-level samples into
//            debounced, hysteretic status flags, and tracks the distance
//            remaining on the current trip.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   1       rising-edge clock
//   rst_n          in   1       asynchronous active-low reset
//   sample_valid   in   1       cpu_temp / fuel_level valid this cycle
//   cpu_temp       in   DATA_W  unsigned temperature sample
//   fuel_level     in   DATA_W  unsigned fuel sample
//   trip_load      in   1       start a new trip with trip_target
//   trip_target    in   DIST_W  trip length in wheel ticks
//   wheel_tick     in   1       one distance unit travelled this cycle
//   cpu_overheated out  1       debounced overheat flag
//   arrived        out  1       trip complete
//   gas_tank_empty out  1       debounced empty-tank flag
//   status_changed out  1       one-cycle pulse after any flag edge
// ============================================================================
module vehicle_sensor_conditioner #(
    parameter int DATA_W      = 8,
    parameter int DIST_W      = 16,
    parameter int TEMP_HOT    = 90,
    parameter int TEMP_COOL   = 80,
    parameter int FUEL_EMPTY  = 5,
    parameter int FUEL_REFILL = 10,
    parameter int DEBOUNCE    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] cpu_temp,
    input  logic [DATA_W-1:0] fuel_level,
    input  logic              trip_load,
    input  logic [DIST_W-1:0] trip_target,
    input  logic              wheel_tick,
    output logic              cpu_overheated,
    output logic              arrived,
    output logic              gas_tank_empty,
    output logic              status_changed
);

    localparam int c_CNT_W = $clog2(DEBOUNCE + 1);

    // Counter value at which the next qualifying sample completes the run.
    localparam logic [c_CNT_W-1:0] c_DEB_LAST = c_CNT_W'(DEBOUNCE - 1);

    localparam logic [DATA_W-1:0] c_TEMP_HOT    = DATA_W'(TEMP_HOT);
    localparam logic [DATA_W-1:0] c_TEMP_COOL   = DATA_W'(TEMP_COOL);
    localparam logic [DATA_W-1:0] c_FUEL_EMPTY  = DATA_W'(FUEL_EMPTY);
    localparam logic [DATA_W-1:0] c_FUEL_REFILL = DATA_W'(FUEL_REFILL);

    // Temperature FSM states
    localparam logic [0:0] c_COOL  = 1'b0;
    localparam logic [0:0] c_HOT   = 1'b1;
    // Fuel FSM states
    localparam logic [0:0] c_OK    = 1'b0;
    localparam logic [0:0] c_EMPTY = 1'b1;

    // Flag vector order {cpu_overheated, arrived, gas_tank_empty}
    localparam logic [2:0] c_FLAGS_RST = 3'b001;

    logic [0:0]         r_temp_state;
    logic [c_CNT_W-1:0] r_temp_cnt;
    logic [0:0]         r_fuel_state;
    logic [c_CNT_W-1:0] r_fuel_cnt;
    logic [DIST_W-1:0]  r_remaining;
    logic               r_trip_active;
    logic               r_arrived;
    logic [2:0]         r_flags_d;
    logic               r_status_changed;

    logic       w_temp_qual;
    logic       w_fuel_qual;
    logic [2:0] w_flags;

    // The qualifying condition depends on the current state: that is what
    // gives the hysteresis band between the two thresholds.
    assign w_temp_qual = (r_temp_state == c_COOL) ? (cpu_temp >= c_TEMP_HOT)
                                                  : (cpu_temp <= c_TEMP_COOL);
    assign w_fuel_qual = (r_fuel_state == c_OK)   ? (fuel_level <= c_FUEL_EMPTY)
                                                  : (fuel_level >= c_FUEL_REFILL);

    // ------------------------------------------------------------------
    // Temperature debounce FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_temp_state <= c_COOL;
            r_temp_cnt   <= '0;
        end else if (sample_valid) begin
            if (w_temp_qual) begin
                if (r_temp_cnt == c_DEB_LAST) begin
                    r_temp_state <= (r_temp_state == c_COOL) ? c_HOT : c_COOL;
                    r_temp_cnt   <= '0;
                end else begin
                    r_temp_cnt   <= r_temp_cnt + 1'b1;
                end
            end else begin
                r_temp_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fuel debounce FSM; starts EMPTY until a refill level is proven
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fuel_state <= c_EMPTY;
            r_fuel_cnt   <= '0;
        end else if (sample_valid) begin
            if (w_fuel_qual) begin
                if (r_fuel_cnt == c_DEB_LAST) begin
                    r_fuel_state <= (r_fuel_state == c_OK) ? c_EMPTY : c_OK;
                    r_fuel_cnt   <= '0;
                end else begin
                    r_fuel_cnt   <= r_fuel_cnt + 1'b1;
                end
            end else begin
                r_fuel_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Trip tracker. trip_active implies remaining >= 1, so the decrement
    // can never wrap. A load in the same cycle as a tick drops the tick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining   <= '0;
            r_trip_active <= 1'b0;
            r_arrived     <= 1'b0;
        end else if (trip_load) begin
            r_remaining <= trip_target;
            if (trip_target == '0) begin
                r_trip_active <= 1'b0;
                r_arrived     <= 1'b1;
            end else begin
                r_trip_active <= 1'b1;
                r_arrived     <= 1'b0;
            end
        end else if (wheel_tick && r_trip_active) begin
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == DIST_W'(1)) begin
                r_trip_active <= 1'b0;
                r_arrived     <= 1'b1;
            end
        end
    end

    assign cpu_overheated = (r_temp_state == c_HOT);
    assign gas_tank_empty = (r_fuel_state == c_EMPTY);
    assign arrived        = r_arrived;

    // ------------------------------------------------------------------
    // Change detector: compares flags with their previous-cycle copy, so
    // the pulse appears the cycle after a flag edge. Several flags moving
    // on one edge collapse into a single pulse.
    // ------------------------------------------------------------------
    assign w_flags = {cpu_overheated, r_arrived, gas_tank_empty};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags_d        <= c_FLAGS_RST;
            r_status_changed <= 1'b0;
        end else begin
            r_flags_d        <= w_flags;
            r_status_changed <= |(w_flags ^ r_flags_d);
        end
    end

    assign status_changed = r_status_changed;

endmodule
`default_nettype wire

// File: tb/tb_vehicle_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_vehicle_sensor_conditioner
// Purpose  : Directed self-checking bench for vehicle_sensor_conditioner.
//            A second instance with DEBOUNCE = 1 shares the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vehicle_sensor_conditioner;

    logic        clk;
    logic        rst_n;
    logic        sample_valid;
    logic [7:0]  cpu_temp;
    logic [7:0]  fuel_level;
    logic        trip_load;
    logic [15:0] trip_target;
    logic        wheel_tick;
    logic        cpu_overheated;
    logic        arrived;
    logic        gas_tank_empty;
    logic        status_changed;
    logic        d1_overheated;
    logic        d1_arrived;
    logic        d1_empty;
    logic        d1_changed;

    int n_tests;
    int n_fail;

    vehicle_sensor_conditioner dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_valid   (sample_valid),
        .cpu_temp       (cpu_temp),
        .fuel_level     (fuel_level),
        .trip_load      (trip_load),
        .trip_target    (trip_target),
        .wheel_tick     (wheel_tick),
        .cpu_overheated (cpu_overheated),
        .arrived        (arrived),
        .gas_tank_empty (gas_tank_empty),
        .status_changed (status_changed)
    );

    vehicle_sensor_conditioner #(.DEBOUNCE(1)) dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_valid   (sample_valid),
        .cpu_temp       (cpu_temp),
        .fuel_level     (fuel_level),
        .trip_load      (trip_load),
        .trip_target    (trip_target),
        .wheel_tick     (wheel_tick),
        .cpu_overheated (d1_overheated),
        .arrived        (d1_arrived),
        .gas_tank_empty (d1_empty),
        .status_changed (d1_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] t, input logic [7:0] f);
        sample_valid = 1'b1;
        cpu_temp     = t;
        fuel_level   = f;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_trip(input logic [15:0] tgt, input logic tick);
        trip_load   = 1'b1;
        trip_target = tgt;
        wheel_tick  = tick;
        step();
        trip_load   = 1'b0;
        wheel_tick  = 1'b0;
    endtask

    task automatic ticks(input int n);
        wheel_tick = 1'b1;
        for (int i = 0; i < n; i++) step();
        wheel_tick = 1'b0;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        cpu_temp     = '0;
        fuel_level   = '0;
        trip_load    = 1'b0;
        trip_target  = '0;
        wheel_tick   = 1'b0;

        // Reset values
        idle(2);
        check_value("rst_overheated", cpu_overheated, 0);
        check_value("rst_arrived", arrived, 0);
        check_value("rst_empty", gas_tank_empty, 1);
        check_value("rst_changed", status_changed, 0);
        rst_n = 1'b1;
        idle(1);

        // Fuel release: 4 samples of fuel 50
        send(8'd50, 8'd50);
        check_value("d1_empty_first", d1_empty, 0);
        send(8'd50, 8'd50);
        send(8'd50, 8'd50);
        check_value("empty_after3", gas_tank_empty, 1);
        send(8'd50, 8'd50);
        check_value("empty_after4", gas_tank_empty, 0);
        check_value("chg_same_edge", status_changed, 0);
        step();
        check_value("chg_pulse", status_changed, 1);
        step();
        check_value("chg_pulse_end", status_changed, 0);

        // Overheat debounce: 95 x3, 85, 95 x4
        send(8'd95, 8'd50);
        check_value("d1_hot_first", d1_overheated, 1);
        send(8'd95, 8'd50);
        send(8'd95, 8'd50);
        send(8'd85, 8'd50);
        check_value("hot_broken_run", cpu_overheated, 0);
        for (int i = 0; i < 3; i++) send(8'd95, 8'd50);
        check_value("hot_after3", cpu_overheated, 0);
        send(8'd95, 8'd50);
        check_value("hot_after4", cpu_overheated, 1);
        step();
        check_value("hot_chg_pulse", status_changed, 1);
        for (int i = 0; i < 3; i++) send(8'd80, 8'd50);
        check_value("cool_after3", cpu_overheated, 1);
        send(8'd80, 8'd50);
        check_value("cool_after4", cpu_overheated, 0);

        // Gaps of 10 idle cycles between valid samples
        for (int i = 0; i < 3; i++) begin
            send(8'd95, 8'd50);
            idle(10);
        end
        check_value("gap_hot_after3", cpu_overheated, 0);
        check_value("gap_cnt_held", dut.r_temp_cnt, 3);
        send(8'd95, 8'd50);
        check_value("gap_hot_after4", cpu_overheated, 1);
        for (int i = 0; i < 4; i++) send(8'd80, 8'd50);
        check_value("gap_cool", cpu_overheated, 0);

        // Trip countdown
        load_trip(16'd3, 1'b0);
        check_value("trip3_loaded", arrived, 0);
        ticks(2);
        check_value("trip3_tick2", arrived, 0);
        ticks(1);
        check_value("trip3_arrived", arrived, 1);
        ticks(2);
        check_value("trip3_extra_arrived", arrived, 1);
        check_value("trip3_extra_rem", dut.r_remaining, 0);

        // Load/tick collision: load wins
        load_trip(16'd5, 1'b1);
        check_value("coll_arrived", arrived, 0);
        check_value("coll_rem", dut.r_remaining, 5);
        ticks(4);
        check_value("coll_tick4", arrived, 0);
        ticks(1);
        check_value("coll_tick5", arrived, 1);

        // Zero-target load
        load_trip(16'd2, 1'b0);
        check_value("pre_zero_arrived", arrived, 0);
        load_trip(16'd0, 1'b0);
        check_value("zero_arrived", arrived, 1);

        // Reset mid-trip and mid-debounce
        load_trip(16'd4, 1'b0);
        ticks(1);
        send(8'd95, 8'd50);
        send(8'd95, 8'd50);
        check_value("mid_cnt2", dut.r_temp_cnt, 2);
        check_value("mid_empty", gas_tank_empty, 0);
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_empty", gas_tank_empty, 1);
        check_value("mid_rst_hot", cpu_overheated, 0);
        check_value("mid_rst_arrived", arrived, 0);
        check_value("mid_rst_changed", status_changed, 0);
        check_value("mid_rst_rem", dut.r_remaining, 0);
        check_value("mid_rst_active", dut.r_trip_active, 0);
        check_value("mid_rst_cnt", dut.r_temp_cnt, 0);
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) send(8'd95, 8'd50);
        check_value("post_rst_hot3", cpu_overheated, 0);
        check_value("post_rst_empty3", gas_tank_empty, 1);
        send(8'd95, 8'd50);
        check_value("post_rst_hot4", cpu_overheated, 1);
        check_value("post_rst_empty4", gas_tank_empty, 0);
        step();
        check_value("dual_chg_pulse", status_changed, 1);
        step();
        check_value("dual_chg_end", status_changed, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vehicle_sensor_conditioner.md
# vehicle_sensor_conditioner

Upstream conditioning stage for the vehicle shutdown/drive decision logic. It registers raw CPU temperature and fuel-level samples, applies hysteresis and consecutive-sample debounce, and tracks distance remaining on the current trip. It produces the three clean, registered status flags the decision stage consumes: `cpu_overheated`, `arrived` and `gas_tank_empty`.

## Interface
Parameters:
- `DATA_W`, 8: width of `cpu_temp` and `fuel_level`.
- `DIST_W`, 16: width of trip distance, in wheel ticks.
- `TEMP_HOT`, 90: a sample with temp ≥ this qualifies as hot.
- `TEMP_COOL`, 80: a sample with temp ≤ this qualifies as cool. Must be < `TEMP_HOT`.
- `FUEL_EMPTY`, 5: a sample with fuel ≤ this qualifies as empty.
- `FUEL_REFILL`, 10: a sample with fuel ≥ this qualifies as refilled. Must be > `FUEL_EMPTY`.
- `DEBOUNCE`, 4: number of consecutive qualifying samples needed to toggle a flag. Must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sample_valid`  in  1  `cpu_temp` and `fuel_level` are valid this cycle.
- `cpu_temp`  in  `DATA_W`  unsigned temperature sample.
- `fuel_level`  in  `DATA_W`  unsigned fuel sample.
- `trip_load`  in  1  start a new trip using `trip_target`.
- `trip_target`  in  `DIST_W`  trip length in wheel ticks.
- `wheel_tick`  in  1  one distance unit travelled this cycle.
- `cpu_overheated`  out  1  debounced overheat flag.
- `arrived`  out  1  trip complete.
- `gas_tank_empty`  out  1  debounced empty flag.
- `status_changed`  out  1  one-cycle pulse when any flag changed on the previous edge.

## Operation
- **Temperature FSM**, states `COOL` and `HOT`, with `temp_cnt`:
  - In `COOL`, a sample with temp ≥ `TEMP_HOT` increments `temp_cnt`. Any other valid sample clears it.
  - When `temp_cnt` would reach `DEBOUNCE`: go to `HOT`, clear `temp_cnt`.
  - In `HOT`, the same rule applies with temp ≤ `TEMP_COOL`, returning to `COOL`.
  - `cpu_overheated` = (state == `HOT`).
- **Fuel FSM**, states `OK` and `EMPTY`, with `fuel_cnt`:
  - Same structure: fuel ≤ `FUEL_EMPTY` moves `OK` → `EMPTY`; fuel ≥ `FUEL_REFILL` moves `EMPTY` → `OK`.
  - `gas_tank_empty` = (state == `EMPTY`).
- **Debounce counters**:
  - Change only when `sample_valid` = 1. Cycles with no valid sample hold them.
  - Samples between the two thresholds are non-qualifying in both states: they clear the counter and leave the state unchanged.
  - Counter width is clog2(`DEBOUNCE`+1).
- **Trip tracker**, with `remaining` (`DIST_W` bits) and `trip_active`:
  - `trip_load`: `remaining` ← `trip_target`, `trip_active` ← 1, `arrived` ← 0.
    - If `trip_target` = 0: `arrived` ← 1 and `trip_active` ← 0 instead.
  - `wheel_tick` while `trip_active`: decrement `remaining`. On the tick that takes 1 → 0, `arrived` ← 1 and `trip_active` ← 0.
  - `wheel_tick` while inactive: ignored. `remaining` never wraps.
  - `arrived` holds until the next `trip_load`.
  - `trip_load` and `wheel_tick` in the same cycle: load wins, the tick is dropped.
- **`status_changed`**: registered XOR of the current flags against their values one cycle earlier.

## Timing
- Reset values: `cpu_overheated` = 0 (`COOL`), `gas_tank_empty` = 1 (`EMPTY`; fuel state is unknown until proven), `arrived` = 0, `status_changed` = 0. `remaining`, `trip_active` and both counters = 0.
- Reset mid-operation aborts the trip and debounce progress immediately, without waiting for a clock edge.
- Flag latency: a flag toggles on the same edge that captures the `DEBOUNCE`-th consecutive qualifying sample. It is visible the cycle after that sample.
- With `DEBOUNCE` = 1, a single qualifying sample toggles the flag on its capture edge.
- `arrived` rises on the edge capturing the final `wheel_tick`, or the `trip_load` carrying a zero target.
- `status_changed` is high for exactly the one cycle after any flag edge. Multiple flags changing on the same edge produce a single pulse.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset and fuel release:** deassert `rst_n` → outputs read 0/0/1/0. Apply 4 valid samples with fuel = 50 → `gas_tank_empty` falls on the 4th capture edge and `status_changed` pulses once.
- **Overheat debounce:** temp = 95 ×3, then 85, then 95 ×4 → `cpu_overheated` rises only after the last group of 4. Then temp = 80 ×4 → it falls.
- **Gaps between samples:** temp = 95 with `sample_valid` low for 10 cycles between samples → the count holds across gaps and the flag rises on the 4th valid sample.
- **Trip countdown:** `trip_target` = 3, then 3 `wheel_tick`s → `arrived` = 1 after the 3rd tick. Extra ticks leave `arrived` = 1 with `remaining` = 0. A zero-target load → `arrived` = 1 the next cycle.
- **Load/tick collision:** `trip_load` with target 5 in the same cycle as `wheel_tick` → `remaining` = 5, so 5 further ticks are needed to arrive.
- **Reset mid-operation:** pull `rst_n` low mid-trip and mid-debounce (count = 2) → outputs return to reset values at once. After release, 4 fresh qualifying samples are needed to toggle a flag.
